window_seq_ctrl: RTL and testbench
==================================

WINDOW_SEQ_CTRL -- requirements
Module: window_seq_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 64: output columns per row (even, >=2).
REQ-002 SHALL have parameter IMG_H, default 64: output rows per frame (>=1).
REQ-003 SHALL have parameter CW, default 8: counter width (2^CW > max(IMG_W, IMG_H)).
REQ-004 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  frame start request, sampled in IDLE only.
REQ-007 SHALL have port abort  in  1  synchronous frame abort.
REQ-008 SHALL have port step_valid  in  1  upstream window data for the current position is valid.
REQ-009 SHALL have port step_ready  out  1  controller accepts the current beat.
REQ-010 SHALL have port out_ready  in  1  downstream interpolator accepts the output beat.
REQ-011 SHALL have port out_valid  out  1  registered output beat valid.
REQ-012 SHALL have port switch  out  1  pixel-pair select driven to the window mux.
REQ-013 SHALL have port mux_sel  out  2  line-buffer rotation select driven to the window mux.
REQ-014 SHALL have port row_adv  out  1  one-cycle pulse: retire oldest line buffer, refill it.
REQ-015 SHALL have port col  out  CW  current column position.
REQ-016 SHALL have port row  out  CW  current row position.
REQ-017 SHALL have port busy  out  1  high in RUN.
REQ-018 SHALL have port done  out  1  one-cycle pulse on frame completion.

Function
REQ-019 SHALL implement states IDLE, RUN, DONE; reset state IDLE.
REQ-020 IDLE: start=1 -> RUN next cycle with col=0, row=0, switch=0, mux_sel=0; start in RUN/DONE SHALL be ignored.
REQ-021 step_ready SHALL equal (state==RUN) && (!out_valid || out_ready), combinational.
REQ-022 A beat SHALL transfer in a cycle where step_valid && step_ready.
REQ-023 On each beat with col<IMG_W-1: col+1, switch toggles, row/mux_sel unchanged.
REQ-024 On a beat with col==IMG_W-1 and row<IMG_H-1: col->0, switch->0, row+1, mux_sel+1 mod 4 (3 wraps to 0), row_adv=1 for exactly the next cycle.
REQ-025 On a beat with col==IMG_W-1 and row==IMG_H-1: state->DONE, col/row/switch/mux_sel hold, no row_adv.
REQ-026 DONE SHALL last one cycle with done=1, then IDLE; out_valid of the last beat SHALL still complete normally.
REQ-027 out_valid SHALL set the cycle after a beat (latency 1), and clear after an out_ready cycle with no new beat; beat and out_ready in same cycle keep it 1.
REQ-028 No beat SHALL be lost or duplicated under any step_valid/out_ready pattern.
REQ-029 abort=1 in RUN/DONE SHALL force IDLE next cycle, clear out_valid, suppress done and row_adv; abort has priority over a simultaneous beat; abort in IDLE has no effect and blocks start that cycle.
REQ-030 switch, mux_sel, col, row SHALL be registered and glitch-free; they change only on beats, start, or reset.
REQ-031 busy SHALL be 1 exactly when state==RUN.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, switch=0, mux_sel=0, col=0, row=0, out_valid=0, row_adv=0, done=0, busy=0, step_ready=0, regardless of clock, including mid-frame.
REQ-033 After rst_n release, no beat or start SHALL be taken before the first rising edge.

Verification (IMG_W=4, IMG_H=2)
REQ-034 start, step_valid=1, out_ready=1 continuous -> 8 beats in 8 cycles; switch 0,1,0,1,0,1,0,1; mux_sel 0 x4 then 1 x4; one row_adv after beat 4; done pulse one cycle after beat 8; busy 8 cycles.
REQ-035 IMG_H=5 frame -> mux_sel sequence per row 0,1,2,3,0 (wrap checked), 4 row_adv pulses.
REQ-036 out_ready=0 for 3 cycles after beat 1 -> out_valid held 1, step_ready=0, col stays 1; on release beats resume, total beats still 8.
REQ-037 abort asserted with step_valid=1 at col=2,row=1 -> next cycle IDLE, out_valid=0, no done, col/row unchanged; new start restarts at col=0,row=0,mux_sel=0.
REQ-038 rst_n=0 asynchronously mid-row (col=3,row=0) -> all outputs at reset values before next clock edge; start pulse during RUN ignored.

Source files
------------

// File: rtl/window_seq_ctrl.sv
// Window sequencer: walks an IMG_W x IMG_H output raster one accepted beat at a
// time, driving pixel-pair/line-buffer selects and a registered output-valid flag.
module window_seq_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          step_valid,
  output logic          step_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          switch,
  output logic [1:0]    mux_sel,
  output logic          row_adv,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic          switch_q, switch_d;
  logic [1:0]    mux_q, mux_d;
  logic          out_valid_q, out_valid_d;
  logic          row_adv_q, row_adv_d;
  logic          beat;

  assign step_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
  // Abort wins over a simultaneous beat, so it is folded into the beat itself.
  assign beat       = step_ready && step_valid && !abort;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    switch_d    = switch_q;
    mux_d       = mux_q;
    out_valid_d = out_valid_q;
    row_adv_d   = 1'b0;

    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d  = S_RUN;
            col_d    = '0;
            row_d    = '0;
            switch_d = 1'b0;
            mux_d    = '0;
          end
        end
        S_RUN: begin
          if (beat) begin
            if (col_q != COL_LAST) begin
              col_d    = col_q + 1'b1;
              switch_d = ~switch_q;
            end else if (row_q != ROW_LAST) begin
              col_d     = '0;
              switch_d  = 1'b0;
              row_d     = row_q + 1'b1;
              mux_d     = mux_q + 1'b1;
              row_adv_d = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      // The final beat's output still drains after the frame ends.
      if (beat) begin
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      switch_q    <= 1'b0;
      mux_q       <= '0;
      out_valid_q <= 1'b0;
      row_adv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      switch_q    <= switch_d;
      mux_q       <= mux_d;
      out_valid_q <= out_valid_d;
      row_adv_q   <= row_adv_d;
    end
  end

  assign out_valid = out_valid_q;
  assign switch    = switch_q;
  assign mux_sel   = mux_q;
  assign row_adv   = row_adv_q;
  assign col       = col_q;
  assign row       = row_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_window_seq_ctrl.sv
// Bench for window_seq_ctrl: 4x2 and 4x5 instances on shared stimulus, checked
// every cycle against a raster-index model plus hand-computed sequences.
module tb_window_seq_ctrl;
  localparam int W  = 4;
  localparam int CW = 8;

  int hh [2] = '{2, 5};

  logic clk = 1'b0;
  logic rst_n, start, abort, step_valid, out_ready;
  logic sr [2], ov [2], sw [2], radv [2], bsy [2], dn [2];
  logic [1:0]    mux  [2];
  logic [CW-1:0] colw [2];
  logic [CW-1:0] roww [2];

  always #5 clk = ~clk;

  window_seq_ctrl #(.IMG_W(4), .IMG_H(2), .CW(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .step_valid(step_valid), .step_ready(sr[0]), .out_ready(out_ready),
    .out_valid(ov[0]), .switch(sw[0]), .mux_sel(mux[0]), .row_adv(radv[0]),
    .col(colw[0]), .row(roww[0]), .busy(bsy[0]), .done(dn[0])
  );

  window_seq_ctrl #(.IMG_W(4), .IMG_H(5), .CW(CW)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .step_valid(step_valid), .step_ready(sr[1]), .out_ready(out_ready),
    .out_valid(ov[1]), .switch(sw[1]), .mux_sel(mux[1]), .row_adv(radv[1]),
    .col(colw[1]), .row(roww[1]), .busy(bsy[1]), .done(dn[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: 0=idle 1=run 2=done; m_n is the linear raster index of the current position.
  int m_st [2];
  int m_n  [2];
  bit m_ov [2];
  bit m_radv [2];

  always @(posedge clk or negedge rst_n) begin
    bit take;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_st[i] = 0; m_n[i] = 0; m_ov[i] = 0; m_radv[i] = 0;
      end else begin
        take = (m_st[i] == 1) && step_valid && (!m_ov[i] || out_ready) && !abort;
        m_radv[i] = 0;
        if (abort && m_st[i] != 0) begin
          m_st[i] = 0;
          m_ov[i] = 0;
        end else begin
          if (m_st[i] == 0) begin
            if (start && !abort) begin m_st[i] = 1; m_n[i] = 0; end
          end else if (m_st[i] == 2) begin
            m_st[i] = 0;
          end else if (take) begin
            if (m_n[i] == W * hh[i] - 1) m_st[i] = 2;
            else begin
              m_radv[i] = (m_n[i] % W == W - 1);
              m_n[i]++;
            end
          end
          if (take) m_ov[i] = 1;
          else if (out_ready) m_ov[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    int ec, er;
    for (int i = 0; i < 2; i++) begin
      ec = m_n[i] % W;
      er = m_n[i] / W;
      chk($sformatf("u%0d.col", i), colw[i], ec);
      chk($sformatf("u%0d.row", i), roww[i], er);
      chk($sformatf("u%0d.switch", i), sw[i], ec % 2);
      chk($sformatf("u%0d.mux_sel", i), mux[i], er % 4);
      chk($sformatf("u%0d.out_valid", i), ov[i], m_ov[i]);
      chk($sformatf("u%0d.row_adv", i), radv[i], m_radv[i]);
      chk($sformatf("u%0d.busy", i), bsy[i], m_st[i] == 1);
      chk($sformatf("u%0d.done", i), dn[i], m_st[i] == 2);
      chk($sformatf("u%0d.step_ready", i), sr[i], (m_st[i] == 1) && (!m_ov[i] || out_ready));
    end
  end

  int hs0 = 0;
  always @(posedge clk) if (rst_n && ov[0] && out_ready) hs0++;

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int maxc);
    int k;
    for (k = 0; k < maxc; k++) begin
      cyc();
      if (dn[0]) break;
    end
    chk("wait_done_timeout", k < maxc, 1);
  endtask

  logic exp_sw [8]  = '{0, 1, 0, 1, 0, 1, 0, 1};
  int   exp_mux [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  int   exp_mux5 [5] = '{0, 1, 2, 3, 0};

  initial begin
    int base, nb0, nr0, nd0, kd0, kr0, nb5, nr5, nd5;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; step_valid = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst.busy", bsy[0], 0);
    chk("rst.col", colw[0], 0);
    chk("rst.step_ready", sr[0], 0);
    chk("rst.out_valid", ov[0], 0);
    #11;
    rst_n = 1'b1;
    cyc();

    // Abort in IDLE blocks a simultaneous start.
    start = 1'b1; abort = 1'b1;
    cyc(); #2;
    chk("idle_abort.busy", bsy[0], 0);
    start = 1'b0; abort = 1'b0;
    cyc();

    // Continuous streaming frame.
    nb0 = 0; nr0 = 0; nd0 = 0; kd0 = -1; kr0 = -1; nb5 = 0; nr5 = 0; nd5 = 0;
    base = hs0;
    start = 1'b1; step_valid = 1'b1; out_ready = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 23; k++) begin
      #2;
      if (k < 8) begin
        chk("t1.switch", sw[0], exp_sw[k]);
        chk("t1.mux_sel", mux[0], exp_mux[k]);
      end
      if (k % 4 == 0 && k < 20) chk("t1.mux5", mux[1], exp_mux5[k / 4]);
      nb0 += int'(bsy[0]);
      if (radv[0]) begin nr0++; kr0 = k; end
      if (dn[0]) begin nd0++; kd0 = k; end
      nb5 += int'(bsy[1]);
      nr5 += int'(radv[1]);
      nd5 += int'(dn[1]);
      cyc();
    end
    chk("t1.busy_cycles", nb0, 8);
    chk("t1.row_adv_count", nr0, 1);
    chk("t1.row_adv_at", kr0, 4);
    chk("t1.done_count", nd0, 1);
    chk("t1.done_at", kd0, 8);
    chk("t1.beats_out", hs0 - base, 8);
    chk("t1.busy5_cycles", nb5, 20);
    chk("t1.row_adv5_count", nr5, 4);
    chk("t1.done5_count", nd5, 1);

    // Downstream stall after the first beat.
    base = hs0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("t2.out_valid", ov[0], 1);
      chk("t2.step_ready", sr[0], 0);
      chk("t2.col", colw[0], 1);
      cyc();
    end
    out_ready = 1'b1;
    wait_done(20);
    cyc(2);
    chk("t2.beats_out", hs0 - base, 8);
    cyc(16);

    // Abort at col=2,row=1 with a beat offered.
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(6);
    #2;
    chk("t3.pre_col", colw[0], 2);
    chk("t3.pre_row", roww[0], 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    #2;
    chk("t3.busy", bsy[0], 0);
    chk("t3.out_valid", ov[0], 0);
    chk("t3.done", dn[0], 0);
    chk("t3.col", colw[0], 2);
    chk("t3.row", roww[0], 1);
    cyc();
    #2;
    chk("t3.done_late", dn[0], 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    #2;
    chk("t3.restart_busy", bsy[0], 1);
    chk("t3.restart_col", colw[0], 0);
    chk("t3.restart_row", roww[0], 0);
    chk("t3.restart_mux", mux[0], 0);

    // Asynchronous reset mid-row at col=3.
    cyc(3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t4.col", colw[0], 0);
    chk("t4.row", roww[0], 0);
    chk("t4.switch", sw[0], 0);
    chk("t4.mux_sel", mux[0], 0);
    chk("t4.out_valid", ov[0], 0);
    chk("t4.row_adv", radv[0], 0);
    chk("t4.done", dn[0], 0);
    chk("t4.busy", bsy[0], 0);
    chk("t4.step_ready", sr[0], 0);
    cyc();
    #2;
    rst_n = 1'b1;
    cyc();

    // Start pulse while running must not restart the raster.
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    #2;
    chk("t4.start_ignored_col", colw[0], 3);
    chk("t4.start_ignored_busy", bsy[0], 1);
    wait_done(20);
    cyc(24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
